// File: rtl/ps2_pkg.sv
// Shared PS/2 Set-2 constants, FSM encoding and sequence helpers used by the
// encode (ascii_to_scan) and decode paths.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;

  localparam logic [2:0] SEQ_LEN_PLAIN = 3'd3;
  localparam logic [2:0] SEQ_LEN_EXT   = 3'd5;
  localparam logic [2:0] SEQ_LEN_SHIFT = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EMIT     = 2'd1,
    ST_GAP_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic       known;
    logic       shift;
    logic       ext;
    logic [7:0] key;
  } lut_t;

  function automatic lut_t lut_ent(logic shift, logic ext, logic [7:0] key);
    return '{known: 1'b1, shift: shift, ext: ext, key: key};
  endfunction

  function automatic logic [2:0] seq_len(logic shift, logic ext);
    if (ext)        return SEQ_LEN_EXT;
    else if (shift) return SEQ_LEN_SHIFT;
    else            return SEQ_LEN_PLAIN;
  endfunction

  // Byte idx of the make/break sequence for one key press.
  function automatic logic [7:0] seq_byte(logic [7:0] key, logic shift, logic ext,
                                          logic [2:0] idx, logic [7:0] shift_code);
    logic [7:0] b;
    b = key;
    if (ext) begin
      case (idx)
        3'd0:    b = PS2_EXT;
        3'd2:    b = PS2_EXT;
        3'd3:    b = PS2_BREAK;
        default: b = key;
      endcase
    end else if (shift) begin
      case (idx)
        3'd0:    b = shift_code;
        3'd2:    b = PS2_BREAK;
        3'd4:    b = PS2_BREAK;
        3'd5:    b = shift_code;
        default: b = key;
      endcase
    end else begin
      if (idx == 3'd1) b = PS2_BREAK;
    end
    return b;
  endfunction

endpackage

// File: rtl/ascii_to_scan_lut.sv
// Combinational ASCII -> Set-2 key lookup: {known, shift, ext, key}.
module ascii_to_scan_lut
  import ps2_pkg::*;
(
  input  logic [7:0] ascii,
  output lut_t       entry
);

  // Letters are indexed by ascii[4:0], so 'a'/'A' land on 1 and 'z'/'Z' on 26.
  function automatic logic [7:0] letter_key(logic [4:0] i);
    case (i)
      5'd1:  return 8'h1C; 5'd2:  return 8'h32; 5'd3:  return 8'h21;
      5'd4:  return 8'h23; 5'd5:  return 8'h24; 5'd6:  return 8'h2B;
      5'd7:  return 8'h34; 5'd8:  return 8'h33; 5'd9:  return 8'h43;
      5'd10: return 8'h3B; 5'd11: return 8'h42; 5'd12: return 8'h4B;
      5'd13: return 8'h3A; 5'd14: return 8'h31; 5'd15: return 8'h44;
      5'd16: return 8'h4D; 5'd17: return 8'h15; 5'd18: return 8'h2D;
      5'd19: return 8'h1B; 5'd20: return 8'h2C; 5'd21: return 8'h3C;
      5'd22: return 8'h2A; 5'd23: return 8'h1D; 5'd24: return 8'h22;
      5'd25: return 8'h35; 5'd26: return 8'h1A;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] digit_key(logic [3:0] i);
    case (i)
      4'd0: return 8'h45; 4'd1: return 8'h16; 4'd2: return 8'h1E;
      4'd3: return 8'h26; 4'd4: return 8'h25; 4'd5: return 8'h2E;
      4'd6: return 8'h36; 4'd7: return 8'h3D; 4'd8: return 8'h3E;
      4'd9: return 8'h46;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    entry = '0;
    if (ascii >= 8'h61 && ascii <= 8'h7A)
      entry = lut_ent(1'b0, 1'b0, letter_key(ascii[4:0]));
    else if (ascii >= 8'h41 && ascii <= 8'h5A)
      entry = lut_ent(1'b1, 1'b0, letter_key(ascii[4:0]));
    else if (ascii >= 8'h30 && ascii <= 8'h39)
      entry = lut_ent(1'b0, 1'b0, digit_key(ascii[3:0]));
    else begin
      case (ascii)
        8'h27: entry = lut_ent(1'b0, 1'b0, 8'h52);
        8'h3D: entry = lut_ent(1'b0, 1'b0, 8'h55);
        8'h3B: entry = lut_ent(1'b0, 1'b0, 8'h4C);
        8'h2C: entry = lut_ent(1'b0, 1'b0, 8'h41);
        8'h2E: entry = lut_ent(1'b0, 1'b0, 8'h49);
        8'h2F: entry = lut_ent(1'b0, 1'b0, 8'h4A);
        8'h2D: entry = lut_ent(1'b0, 1'b0, 8'h4E);
        8'h5B: entry = lut_ent(1'b0, 1'b0, 8'h54);
        8'h5C: entry = lut_ent(1'b0, 1'b0, 8'h5D);
        8'h5D: entry = lut_ent(1'b0, 1'b0, 8'h5B);
        8'h60: entry = lut_ent(1'b0, 1'b0, 8'h0E);
        8'h21: entry = lut_ent(1'b1, 1'b0, 8'h16);
        8'h22: entry = lut_ent(1'b1, 1'b0, 8'h52);
        8'h23: entry = lut_ent(1'b1, 1'b0, 8'h26);
        8'h24: entry = lut_ent(1'b1, 1'b0, 8'h25);
        8'h25: entry = lut_ent(1'b1, 1'b0, 8'h2E);
        8'h26: entry = lut_ent(1'b1, 1'b0, 8'h3D);
        8'h28: entry = lut_ent(1'b1, 1'b0, 8'h46);
        8'h29: entry = lut_ent(1'b1, 1'b0, 8'h45);
        8'h2A: entry = lut_ent(1'b1, 1'b0, 8'h3E);
        8'h2B: entry = lut_ent(1'b1, 1'b0, 8'h55);
        8'h3A: entry = lut_ent(1'b1, 1'b0, 8'h4C);
        8'h3C: entry = lut_ent(1'b1, 1'b0, 8'h41);
        8'h3E: entry = lut_ent(1'b1, 1'b0, 8'h49);
        8'h3F: entry = lut_ent(1'b1, 1'b0, 8'h4A);
        8'h40: entry = lut_ent(1'b1, 1'b0, 8'h1E);
        8'h5E: entry = lut_ent(1'b1, 1'b0, 8'h36);
        8'h5F: entry = lut_ent(1'b1, 1'b0, 8'h4E);
        8'h7B: entry = lut_ent(1'b1, 1'b0, 8'h54);
        8'h7C: entry = lut_ent(1'b1, 1'b0, 8'h5D);
        8'h7D: entry = lut_ent(1'b1, 1'b0, 8'h5B);
        8'h7E: entry = lut_ent(1'b1, 1'b0, 8'h0E);
        8'h1B: entry = lut_ent(1'b0, 1'b0, 8'h76);
        8'h0D: entry = lut_ent(1'b0, 1'b0, 8'h5A);
        8'h20: entry = lut_ent(1'b0, 1'b0, 8'h29);
        8'h08: entry = lut_ent(1'b0, 1'b0, 8'h66);
        8'h09: entry = lut_ent(1'b0, 1'b0, 8'h0D);
        8'h11: entry = lut_ent(1'b0, 1'b1, 8'h75);
        8'h12: entry = lut_ent(1'b0, 1'b1, 8'h6B);
        8'h13: entry = lut_ent(1'b0, 1'b1, 8'h72);
        8'h14: entry = lut_ent(1'b0, 1'b1, 8'h74);
        default: entry = '0;
      endcase
    end
  end

endmodule

// File: rtl/ascii_to_scan.sv
// Encodes one ASCII character per handshake into the PS/2 Set-2 make/break
// byte sequence, with optional idle gap between output bytes.
module ascii_to_scan
  import ps2_pkg::*;
#(
  parameter logic [7:0] SHIFT_CODE = PS2_LSHIFT,
  parameter int         GAP        = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_ascii,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [7:0] scancode,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       unknown_char
);

  localparam logic [7:0] GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  lut_t       lut;
  state_t     state;
  logic [2:0] idx, last_idx;
  logic [7:0] gap_cnt;
  logic [7:0] key_r;
  logic       shift_r, ext_r;
  logic       accept;
  logic [2:0] nxt_idx;

  ascii_to_scan_lut u_lut (.ascii(char_ascii), .entry(lut));

  assign char_ready = (state == ST_IDLE);
  assign accept     = char_valid && char_ready;
  assign nxt_idx    = idx + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      last_idx     <= '0;
      gap_cnt      <= '0;
      key_r        <= '0;
      shift_r      <= 1'b0;
      ext_r        <= 1'b0;
      scancode     <= '0;
      code_valid   <= 1'b0;
      unknown_char <= 1'b0;
    end else begin
      unknown_char <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (lut.known) begin
              key_r      <= lut.key;
              shift_r    <= lut.shift;
              ext_r      <= lut.ext;
              idx        <= '0;
              last_idx   <= seq_len(lut.shift, lut.ext) - 3'd1;
              scancode   <= seq_byte(lut.key, lut.shift, lut.ext, 3'd0, SHIFT_CODE);
              code_valid <= 1'b1;
              state      <= ST_EMIT;
            end else begin
              unknown_char <= 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (code_ready) begin
            if (idx == last_idx) begin
              idx        <= '0;
              code_valid <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              idx <= nxt_idx;
              if (GAP > 0) begin
                code_valid <= 1'b0;
                gap_cnt    <= '0;
                state      <= ST_GAP_WAIT;
              end else begin
                scancode <= seq_byte(key_r, shift_r, ext_r, nxt_idx, SHIFT_CODE);
              end
            end
          end
        end
        ST_GAP_WAIT: begin
          // idx already points at the next byte; present it once GAP idle cycles elapse.
          if (gap_cnt == GAP_LAST) begin
            scancode   <= seq_byte(key_r, shift_r, ext_r, idx, SHIFT_CODE);
            code_valid <= 1'b1;
            state      <= ST_EMIT;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_to_scan.sv
// Directed bench for ascii_to_scan: default, SHIFT_CODE=59 and GAP=3 instances.
module tb_ascii_to_scan;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       char_ascii;
  logic             code_ready;
  logic [2:0]       char_valid;
  logic [2:0]       char_ready, code_valid, unknown_char;
  logic [2:0][7:0]  sc;

  always #5 clk = ~clk;

  ascii_to_scan #(.SHIFT_CODE(8'h12), .GAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .char_ascii(char_ascii), .char_valid(char_valid[0]),
    .char_ready(char_ready[0]), .scancode(sc[0]), .code_valid(code_valid[0]),
    .code_ready(code_ready), .unknown_char(unknown_char[0]));

  ascii_to_scan #(.SHIFT_CODE(8'h59), .GAP(0)) u_dut1 (
    .clk(clk), .rst(rst), .char_ascii(char_ascii), .char_valid(char_valid[1]),
    .char_ready(char_ready[1]), .scancode(sc[1]), .code_valid(code_valid[1]),
    .code_ready(code_ready), .unknown_char(unknown_char[1]));

  ascii_to_scan #(.SHIFT_CODE(8'h12), .GAP(3)) u_dut2 (
    .clk(clk), .rst(rst), .char_ascii(char_ascii), .char_valid(char_valid[2]),
    .char_ready(char_ready[2]), .scancode(sc[2]), .code_valid(code_valid[2]),
    .code_ready(code_ready), .unknown_char(unknown_char[2]));

  int checks = 0;
  int errors = 0;

  logic [7:0] byte_q[$];
  logic [7:0] exp_q[$];
  int         gap_q[$];
  int         last_xfer_cyc, rdy_cyc, hold_err, stalls;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic chk_seq(input string tag);
    chk({tag, "_len"}, byte_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < byte_q.size()) chk($sformatf("%s_b%0d", tag, i), byte_q[i], exp_q[i]);
  endtask

  // Present one character to instance sel, then record every transfer until char_ready returns.
  task automatic run_char(input string tag, input int sel, input logic [7:0] ch,
                          input bit toggle, input int max_cyc);
    bit         pend, after;
    logic [7:0] pend_b;
    int         idle_run;
    byte_q.delete(); gap_q.delete();
    hold_err = 0; stalls = 0; last_xfer_cyc = -1; rdy_cyc = -1;
    pend = 0; after = 0; idle_run = 0; pend_b = '0;
    @(negedge clk);
    char_ascii      = ch;
    char_valid      = '0;
    char_valid[sel] = 1'b1;
    code_ready      = 1'b1;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clk);
      char_valid = '0;
      code_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (cyc == 0) chk({tag, "_busy"}, char_ready[sel], 1'b0);
      if (cyc > 0 && char_ready[sel]) begin
        rdy_cyc = cyc;
        break;
      end
      if (code_valid[sel]) begin
        if (pend && sc[sel] !== pend_b) hold_err++;
        if (after) begin
          gap_q.push_back(idle_run);
          after = 0;
        end
        idle_run = 0;
        if (code_ready) begin
          byte_q.push_back(sc[sel]);
          last_xfer_cyc = cyc;
          pend  = 0;
          after = 1;
        end else begin
          stalls++;
          pend   = 1;
          pend_b = sc[sel];
        end
      end else begin
        idle_run++;
      end
    end
    if (rdy_cyc < 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_unknown(input string tag, input logic [7:0] ch);
    @(negedge clk);
    char_ascii    = ch;
    char_valid    = 3'b001;
    code_ready    = 1'b1;
    @(negedge clk);
    char_valid = '0;
    chk({tag, "_unk_pulse"}, unknown_char[0], 1'b1);
    chk({tag, "_no_valid"}, code_valid[0], 1'b0);
    chk({tag, "_ready"}, char_ready[0], 1'b1);
    @(negedge clk);
    chk({tag, "_unk_clear"}, unknown_char[0], 1'b0);
    chk({tag, "_no_valid2"}, code_valid[0], 1'b0);
  endtask

  initial begin
    rst = 1'b1; char_ascii = '0; char_valid = '0; code_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_scancode", sc[0], 8'h00);
    chk("rst_code_valid", code_valid[0], 1'b0);
    chk("rst_unknown", unknown_char[0], 1'b0);
    chk("rst_char_ready", char_ready[0], 1'b1);
    rst = 1'b0;
    @(negedge clk);

    run_char("a", 0, 8'h61, 1'b0, 20);
    exp_q = '{8'h1C, 8'hF0, 8'h1C};
    chk_seq("a");
    chk("a_span", last_xfer_cyc, 2);
    chk("a_rdy_next", rdy_cyc, last_xfer_cyc + 1);

    run_char("A", 0, 8'h41, 1'b0, 20);
    exp_q = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12};
    chk_seq("A");
    chk("A_span", last_xfer_cyc, 5);
    chk("A_rdy_next", rdy_cyc, last_xfer_cyc + 1);

    run_char("A59", 1, 8'h41, 1'b0, 20);
    exp_q = '{8'h59, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h59};
    chk_seq("A59");

    run_char("up", 0, 8'h11, 1'b1, 30);
    exp_q = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    chk_seq("up");
    chk("up_hold", hold_err, 0);
    chk("up_stalled", stalls > 0, 1'b1);

    run_unknown("nul", 8'h00);
    run_unknown("c3", 8'hC3);

    run_char("tilde", 2, 8'h7E, 1'b0, 50);
    exp_q = '{8'h12, 8'h0E, 8'hF0, 8'h0E, 8'hF0, 8'h12};
    chk_seq("tilde");
    chk("tilde_ngaps", gap_q.size(), 5);
    for (int i = 0; i < gap_q.size(); i++) chk($sformatf("tilde_gap%0d", i), gap_q[i], 3);

    // Reset after the second byte of '@' must abort the sequence outright.
    @(negedge clk);
    char_ascii = 8'h40; char_valid = 3'b001; code_ready = 1'b1;
    @(negedge clk);
    char_valid = '0;
    chk("at_b0", sc[0], 8'h12);
    @(negedge clk);
    chk("at_b1", sc[0], 8'h1E);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("at_rst_scancode", sc[0], 8'h00);
    chk("at_rst_valid", code_valid[0], 1'b0);
    chk("at_rst_ready", char_ready[0], 1'b1);
    chk("at_rst_unknown", unknown_char[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("at_quiet%0d", i), code_valid[0], 1'b0);
    end

    run_char("one", 0, 8'h31, 1'b0, 20);
    exp_q = '{8'h16, 8'hF0, 8'h16};
    chk_seq("one");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascii_to_scan.md
# ascii_to_scan

Inverse of the keyboard decode path: accepts one 8-bit ASCII character per handshake and emits the PS/2 Set-2 byte sequence a keyboard would send to type it. The sequence covers make, break, left-shift wrap, and the E0 prefix for arrows. It sits between a character source (CPU-side TX register or test pattern generator) and the PS/2 device-side byte transmitter or keyboard emulator. It lets the system loop text back through the keyboard decode path.

## Interface
Parameters:
- SHIFT_CODE, 8'h12, make code used for shift wrapping (left shift).
- GAP, 0, minimum idle cycles inserted between consecutive output bytes (0..255).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- char_ascii  in  8  character to encode; sampled on accept.
- char_valid  in  1  char_ascii is valid.
- char_ready  out  1  block is idle and can accept a character (high only in IDLE).
- scancode  out  8  current output byte.
- code_valid  out  1  scancode is valid.
- code_ready  in  1  downstream accepts scancode this cycle.
- unknown_char  out  1  one-cycle pulse: accepted character has no mapping, so no bytes are emitted.

## Operation
- Accept occurs when char_valid && char_ready. Lookup yields key (8b), shift, ext, known; these are registered at accept.
- Mapping, all hex:
  - a–z (61–7A), no shift; A–Z (41–5A), shift. Keys for a..z in order: 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A.
  - Digits 0–9 (30–39), no shift. Keys in order: 45 16 1E 26 25 2E 36 3D 3E 46.
  - Unshifted punctuation: ' 52, = 55, ; 4C, , 41, . 49, / 4A, - 4E, [ 54, \ 5D, ] 5B, ` 0E.
  - Shifted punctuation: ! 16, " 52, # 26, $ 25, % 2E, & 3D, ( 46, ) 45, * 3E, + 55, : 4C, < 41, > 49, ? 4A, @ 1E, ^ 36, _ 4E, { 54, | 5D, } 5B, ~ 0E.
  - Controls, no shift: 1B→76, 0D→5A, 20→29, 08→66, 09→0D.
  - Extended, no shift: 11→75, 12→6B, 13→72, 14→74.
  - Every other code, including 00 and 80–FF, is unknown.
- Sequences, where K is the key:
  - Plain: K, F0, K.
  - Shift: SHIFT_CODE, K, F0, K, F0, SHIFT_CODE.
  - Extended: E0, K, E0, F0, K.
- Unknown character: consumed, unknown_char pulses, no code_valid, return to IDLE.
- FSM states:
  - IDLE: accept → EMIT, or → IDLE with unknown_char for an unmapped character.
  - EMIT: present byte[idx]; on code_ready, idx+1. After the last byte → IDLE; otherwise → GAP_WAIT if GAP>0, else stay in EMIT.
  - GAP_WAIT: count GAP cycles with code_valid=0, then → EMIT.
- idx is a 3-bit counter. The sequence length is 3, 5 or 6, fixed at accept.

## Timing
- Reset values: scancode=00, code_valid=0, unknown_char=0, char_ready=1, state=IDLE, idx=0. Reset asserted mid-sequence aborts immediately; no partial break is emitted afterward.
- Latency: first byte valid the cycle after accept. unknown_char is high the cycle after accept.
- scancode and code_valid are registered. They hold stable while code_valid && !code_ready.
- With code_ready=1 and GAP=0, one byte transfers per cycle. 'A' occupies 6 consecutive valid cycles, and char_ready returns high the cycle after the last transfer.
- char_ready is low from the cycle after accept until IDLE is re-entered, so no overlap between characters is possible.
- code_ready asserted while code_valid=0 is ignored.

## Structure
- Shared package ps2_pkg holds:
  - constants PS2_BREAK=8'hF0, PS2_EXT=8'hE0, PS2_LSHIFT=8'h12;
  - the FSM state encoding;
  - the sequence-length constants.
  The decode path reuses the same constants.
- Sub-module ascii_to_scan_lut: purely combinational lookup, ascii → {known, shift, ext, key[7:0]}.
- The top level holds the FSM, idx counter, gap counter and output registers.

## Test plan
- 'a' (61) with code_ready=1, GAP=0 → bytes 1C, F0, 1C on consecutive cycles; char_ready high the cycle after.
- 'A' (41) → 12, 1C, F0, 1C, F0, 12. Repeat with SHIFT_CODE=59 → 59, 1C, F0, 1C, F0, 59.
- 11 (up arrow) with code_ready toggling 1/0 each cycle → E0, 75, E0, F0, 75. Each byte is held stable until accepted.
- 00 and C3 → unknown_char pulse one cycle after accept; code_valid never asserted; char_ready high again.
- '~' (7E) with GAP=3 → 12, 0E, F0, 0E, F0, 12 with exactly 3 invalid cycles between bytes.
- rst asserted after the second byte of '@' (40) → outputs return to reset values immediately. The next char '1' (31) emits exactly 16, F0, 16.
